// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues single-outstanding imem reads and buffers returned instructions for cu.
// Define FETCH_PERF_EN to add the perf_fetched / perf_squashed counters.
module fetch_unit #(
   parameter int unsigned PC_W  = 8,
   parameter int unsigned IW    = 17,
   parameter int unsigned DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [IW-1:0]   imem_data,
   input  logic            redirect,
   input  logic [PC_W-1:0] redirect_pc,
   output logic [IW-1:0]   instr,
   output logic [PC_W-1:0] instr_pc,
   output logic            instr_valid,
   input  logic            instr_ready
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0]     perf_fetched,
   output logic [15:0]     perf_squashed
`endif
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

   state_t          r_state;
   logic [PC_W-1:0] r_fetch_pc;
   logic [PC_W-1:0] r_addr;
   logic            r_req;
   logic [PW-1:0]   r_wptr;
   logic [PW-1:0]   r_rptr;
   logic [CW-1:0]   r_count;
   logic [IW-1:0]   r_mem_data [DEPTH];
   logic [PC_W-1:0] r_mem_pc   [DEPTH];

   logic            w_empty;
   logic            w_push;
   logic            w_pop;
   logic [CW-1:0]   w_count_nxt;

   // A redirect suppresses both FIFO ports in its cycle.
   assign w_empty = (r_count == '0);
   assign w_push  = (r_state == S_WAIT) && imem_ack && !redirect;
   assign w_pop   = !w_empty && instr_ready && !redirect;

   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop)
         w_count_nxt = r_count + 1'b1;
      else if (!w_push && w_pop)
         w_count_nxt = r_count - 1'b1;
   end

   assign imem_req    = r_req;
   assign imem_addr   = r_addr;
   assign instr_valid = !w_empty;
   assign instr       = w_empty ? '0 : r_mem_data[r_rptr];
   assign instr_pc    = w_empty ? '0 : r_mem_pc[r_rptr];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_data[r_wptr] <= imem_data;
         r_mem_pc[r_wptr]   <= r_addr;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_fetch_pc <= '0;
         r_addr     <= '0;
         r_req      <= 1'b0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
      end else if (redirect) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_fetch_pc <= redirect_pc;
         // An ack in the redirect cycle retires the squashed read; otherwise it must still be drained.
         case (r_state)
            S_WAIT, S_DRAIN: begin
               if (imem_ack) begin
                  r_state <= S_IDLE;
                  r_req   <= 1'b0;
               end else begin
                  r_state <= S_DRAIN;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_req   <= 1'b0;
            end
         endcase
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         r_count <= w_count_nxt;
         case (r_state)
            S_IDLE: begin
               if (r_count < DEPTH_C) begin
                  r_state <= S_WAIT;
                  r_req   <= 1'b1;
                  r_addr  <= r_fetch_pc;
               end
            end
            S_WAIT: begin
               if (imem_ack) begin
                  r_fetch_pc <= r_fetch_pc + 1'b1;
                  if (w_count_nxt < DEPTH_C) begin
                     r_addr <= r_fetch_pc + 1'b1;
                  end else begin
                     r_state <= S_IDLE;
                     r_req   <= 1'b0;
                  end
               end
            end
            S_DRAIN: begin
               if (imem_ack) begin
                  r_state <= S_IDLE;
                  r_req   <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_req   <= 1'b0;
            end
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   logic [15:0] r_perf_fetched;
   logic [15:0] r_perf_squashed;
   logic [16:0] w_sq_sum;

   // Squash count: buffered entries plus the read in flight when the redirect lands in WAIT.
   assign w_sq_sum = {1'b0, r_perf_squashed} + 17'(r_count) + 17'(r_state == S_WAIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_perf_fetched  <= '0;
         r_perf_squashed <= '0;
      end else begin
         if (w_pop && (r_perf_fetched != '1))
            r_perf_fetched <= r_perf_fetched + 1'b1;
         if (redirect)
            r_perf_squashed <= w_sq_sum[16] ? '1 : w_sq_sum[15:0];
      end
   end

   assign perf_fetched  = r_perf_fetched;
   assign perf_squashed = r_perf_squashed;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench; expected {pc, instr} pairs are queued per step and checked on each consumed instruction.
`timescale 1ns/1ps
module tb_fetch_unit;

   localparam int unsigned PC_W = 8;
   localparam int unsigned IW   = 17;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_ack;
   logic [IW-1:0]   imem_data;
   logic            redirect = 1'b0;
   logic [PC_W-1:0] redirect_pc = '0;
   logic [IW-1:0]   instr;
   logic [PC_W-1:0] instr_pc;
   logic            instr_valid;
   logic            instr_ready = 1'b0;
`ifdef FETCH_PERF_EN
   logic [15:0]     perf_fetched;
   logic [15:0]     perf_squashed;
`endif

   fetch_unit #(.PC_W(PC_W), .IW(IW), .DEPTH(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_data   (imem_data),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched  (perf_fetched),
      .perf_squashed (perf_squashed)
`endif
   );

   always #5 clk = ~clk;

   // Memory model: acks once the request has been held for lat cycles.
   logic [IW-1:0] mem [256];
   int unsigned   lat = 0;
   int unsigned   wc  = 0;

   assign imem_ack  = imem_req && (wc >= lat);
   assign imem_data = mem[imem_addr];

   always @(posedge clk or posedge rst) begin
      if (rst)                        wc <= 0;
      else if (!imem_req || imem_ack) wc <= 0;
      else                            wc <= wc + 1;
   end

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [IW-1:0]   d;
   } exp_t;

   exp_t sb[$];
   exp_t m_e;
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_at(input int unsigned a);
      exp_t e;
      e.pc = PC_W'(a);
      e.d  = mem[a];
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits until every queued instruction is consumed, then stops consuming after the final pop edge.
   task automatic drain(input string tag);
      int unsigned k;
      k = 0;
      #1;
      while (sb.size() != 0 && k < 200) begin
         @(negedge clk);
         #1;
         k++;
      end
      chk(tag, 32'(sb.size()), 32'd0);
      @(posedge clk);
      #1;
      instr_ready = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst && instr_valid && instr_ready && !redirect) begin
         n_cmp++;
         assert (sb.size() != 0) else begin
            n_err++;
            $error("FAIL unexpected_instr: observed pc 0x%0h, expected no instruction", instr_pc);
         end
         if (sb.size() != 0) begin
            m_e = sb.pop_front();
            chk("instr", 32'(instr), 32'(m_e.d));
            chk("instr_pc", 32'(instr_pc), 32'(m_e.pc));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed no end of test by %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 17'(i * 389 + 4660);
      mem[0] = 17'h0E103;
      mem[1] = 17'h0E001;
      mem[2] = 17'h01102;
      mem[3] = 17'h0F2FF;

      // Reset values
      tick();
      tick();
      @(negedge clk);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_addr", 32'(imem_addr), 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", 32'(instr), 32'd0);
      chk("rst_instr_pc", 32'(instr_pc), 32'd0);

      // Linear fetch with same-cycle ack
      @(posedge clk);
      #1;
      sb.push_back({8'h00, 17'h0E103});
      sb.push_back({8'h01, 17'h0E001});
      sb.push_back({8'h02, 17'h01102});
      sb.push_back({8'h03, 17'h0F2FF});
      instr_ready = 1'b1;
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("first_req", 32'(imem_req), 32'd1);
      chk("first_addr", 32'(imem_addr), 32'd0);
      chk("first_valid_early", 32'(instr_valid), 32'd0);
      @(negedge clk);
      chk("first_valid", 32'(instr_valid), 32'd1);
      chk("first_pc", 32'(instr_pc), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stream_valid", 32'(instr_valid), 32'd1);
      end
      drain("lin_drain");

      // Backpressure
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("bp_req_drop", 32'(imem_req), 32'd0);
      chk("bp_valid", 32'(instr_valid), 32'd1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("bp_req_hold", 32'(imem_req), 32'd0);
         chk("bp_head_pc", 32'(instr_pc), 32'd0);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) expect_at(i);
      instr_ready = 1'b1;
      for (int i = 0; i < 10 && !imem_req; i++) @(negedge clk);
      chk("bp_resume_addr", 32'(imem_addr), 32'd2);
      drain("bp_drain");

      // Slow memory: ack three cycles after request
      rst = 1'b1;
      lat = 3;
      for (int i = 0; i < 4; i++) expect_at(i);
      instr_ready = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("slow_req", 32'(imem_req), 32'd1);
         chk("slow_addr", 32'(imem_addr), 32'd0);
      end
      drain("slow_drain");

      // Redirects: from IDLE with two buffered, then with a read outstanding on addr 5
      rst = 1'b1;
      lat = 0;
      for (int i = 0; i < 4; i++) expect_at(i);
      instr_ready = 1'b1;
      tick();
      rst = 1'b0;
      drain("r_pre_drain");
      repeat (3) tick();
      @(negedge clk);
      chk("r_full_valid", 32'(instr_valid), 32'd1);
      chk("r_full_pc", 32'(instr_pc), 32'd4);
      chk("r_full_req", 32'(imem_req), 32'd0);
`ifdef FETCH_PERF_EN
      chk("perf_fetched_4", 32'(perf_fetched), 32'd4);
`endif
      @(posedge clk);
      #1;
      lat = 4;
      redirect = 1'b1;
      redirect_pc = 8'h05;
      tick();
      redirect = 1'b0;
      @(negedge clk);
      chk("r_valid_drop", 32'(instr_valid), 32'd0);
      chk("r_instr_zero", 32'(instr), 32'd0);
      chk("r_pc_zero", 32'(instr_pc), 32'd0);
      for (int i = 0; i < 10 && !imem_req; i++) @(negedge clk);
      chk("r_wait_addr", 32'(imem_addr), 32'd5);
      @(posedge clk);
      #1;
      redirect = 1'b1;
      redirect_pc = 8'h40;
      tick();
      redirect = 1'b0;
      lat = 0;
      @(negedge clk);
      chk("drain_req", 32'(imem_req), 32'd1);
      chk("drain_addr", 32'(imem_addr), 32'd5);
      chk("drain_valid", 32'(instr_valid), 32'd0);
`ifdef FETCH_PERF_EN
      chk("perf_fetched", 32'(perf_fetched), 32'd4);
      chk("perf_squashed", 32'(perf_squashed), 32'd3);
`endif
      expect_at(8'h40);
      expect_at(8'h41);
      instr_ready = 1'b1;
      for (int i = 0; i < 10 && !(imem_req && imem_addr != 8'h05); i++) @(negedge clk);
      chk("r_target_addr", 32'(imem_addr), 32'h40);
      drain("r_drain");

      // Wrap of the fetch pc
      redirect = 1'b1;
      redirect_pc = 8'hFF;
      expect_at(8'hFF);
      expect_at(8'h00);
      instr_ready = 1'b1;
      tick();
      redirect = 1'b0;
      drain("wrap_drain");

      // Redirect in the same cycle as ack: acked data must be dropped
      rst = 1'b1;
      lat = 2;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 20 && !imem_ack; i++) @(negedge clk);
      chk("rb_ack_seen", 32'(imem_ack), 32'd1);
      redirect = 1'b1;
      redirect_pc = 8'h20;
      tick();
      redirect = 1'b0;
      @(negedge clk);
      chk("rb_req", 32'(imem_req), 32'd0);
      chk("rb_valid", 32'(instr_valid), 32'd0);
      expect_at(8'h20);
      instr_ready = 1'b1;
      drain("rb_drain");

      // Asynchronous reset in the middle of a read
      rst = 1'b1;
      lat = 0;
      tick();
      rst = 1'b0;
      repeat (5) tick();
      lat = 5;
      expect_at(0);
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      tick();
      @(negedge clk);
      chk("mr_req", 32'(imem_req), 32'd1);
      chk("mr_addr", 32'(imem_addr), 32'd2);
      chk("mr_valid", 32'(instr_valid), 32'd1);
      chk("mr_head_pc", 32'(instr_pc), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_req", 32'(imem_req), 32'd0);
      chk("ar_addr", 32'(imem_addr), 32'd0);
      chk("ar_valid", 32'(instr_valid), 32'd0);
      chk("ar_instr", 32'(instr), 32'd0);
      chk("ar_instr_pc", 32'(instr_pc), 32'd0);
`ifdef FETCH_PERF_EN
      chk("ar_perf_fetched", 32'(perf_fetched), 32'd0);
      chk("ar_perf_squashed", 32'(perf_squashed), 32'd0);
`endif
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
